// File: rtl/calc1_pkg.sv
// Shared encodings for the calc1 request/response protocol.
// The driver, checker, reference model and responder all import these
// constants, so every agent agrees on the command and response codes.
package calc1_pkg;

  localparam int DATA_W = 32;

  // Command codes carried on req_cmd_in. Any other non-zero code is invalid.
  localparam logic [0:3] CMD_NOP = 4'd0;
  localparam logic [0:3] CMD_ADD = 4'd1;
  localparam logic [0:3] CMD_SUB = 4'd2;
  localparam logic [0:3] CMD_SHL = 4'd5;
  localparam logic [0:3] CMD_SHR = 4'd6;

  // Response codes carried on out_resp.
  localparam logic [0:1] RESP_NONE = 2'd0;
  localparam logic [0:1] RESP_OK   = 2'd1;
  localparam logic [0:1] RESP_OVF  = 2'd2;
  localparam logic [0:1] RESP_INV  = 2'd3;

  // Responder transaction states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OP2  = 2'd1,
    EXEC = 2'd2,
    RESP = 2'd3
  } state_t;

endpackage

// File: rtl/calc1_port_responder_if.sv
// Single calc1 port: request from the driver, response back from the
// responder.
//   req_cmd_in  [0:3]  command (master -> slave)
//   req_data_in [0:31] operand1 in the command cycle, operand2 the next
//   out_resp    [0:1]  response code, non-zero for one cycle only
//   out_data    [0:31] result, zero whenever out_resp is zero
//   busy               transaction in flight
//   drop_count  [0:7]  saturating count of commands refused while busy
// The master modport is the driver side, the slave modport the responder.
interface calc1_port_responder_if;

  logic [0:3]                     req_cmd_in;
  logic [0:calc1_pkg::DATA_W-1]   req_data_in;
  logic [0:1]                     out_resp;
  logic [0:calc1_pkg::DATA_W-1]   out_data;
  logic                           busy;
  logic [0:7]                     drop_count;

  modport master (
    output req_cmd_in,
    output req_data_in,
    input  out_resp,
    input  out_data,
    input  busy,
    input  drop_count
  );

  modport slave (
    input  req_cmd_in,
    input  req_data_in,
    output out_resp,
    output out_data,
    output busy,
    output drop_count
  );

endinterface

// File: rtl/calc1_port_responder_alu.sv
// Combinational calc1 execute unit.
//   cmd  [0:3]  latched command
//   op1  [0:31] first operand
//   op2  [0:31] second operand (only the low SHIFT_BITS used for shifts)
//   resp [0:1]  OK, OVF (add carry / sub borrow) or INV (unknown command)
//   data [0:31] result; forced to zero unless resp is OK
// Bit 0 is the MSB throughout; all arithmetic is unsigned.
module calc1_alu
  import calc1_pkg::*;
#(
  parameter int SHIFT_BITS = 5
) (
  input  logic [0:3]        cmd,
  input  logic [0:DATA_W-1] op1,
  input  logic [0:DATA_W-1] op2,
  output logic [0:1]        resp,
  output logic [0:DATA_W-1] data
);

  // sum[0] is the carry out, sum[1:DATA_W] the 32-bit result.
  logic [0:DATA_W]         sum;
  logic [SHIFT_BITS-1:0]   shamt;

  always_comb begin
    sum   = {1'b0, op1} + {1'b0, op2};
    // Low-order bits of op2 sit at the high indices of the [0:31] range.
    shamt = op2[DATA_W-SHIFT_BITS +: SHIFT_BITS];
    resp  = RESP_INV;
    data  = '0;
    case (cmd)
      CMD_ADD: begin
        if (sum[0]) begin
          resp = RESP_OVF;
        end else begin
          resp = RESP_OK;
          data = sum[1:DATA_W];
        end
      end
      CMD_SUB: begin
        if (op2 > op1) begin
          resp = RESP_OVF;
        end else begin
          resp = RESP_OK;
          data = op1 - op2;
        end
      end
      CMD_SHL: begin
        resp = RESP_OK;
        data = op1 << shamt;
      end
      CMD_SHR: begin
        resp = RESP_OK;
        data = op1 >> shamt;
      end
      default: begin
        resp = RESP_INV;
        data = '0;
      end
    endcase
  end

endmodule

// File: rtl/calc1_port_responder.sv
// calc1 single-port responder: captures a command plus two operands,
// waits LATENCY execute cycles and returns a one-cycle response pulse.
//   c_clk   clock, all logic on the rising edge
//   reset   synchronous active-high reset; aborts any transaction silently
//   bus     calc1_port_responder_if slave modport (request in, response out)
// Parameters:
//   LATENCY     execute cycles between operand2 capture and response (1..15)
//   SHIFT_BITS  low operand2 bits used as the shift amount
// Only one transaction is in flight; commands arriving while busy are
// dropped and counted, and never disturb the transaction in flight.
module calc1_port_responder
  import calc1_pkg::*;
#(
  parameter int LATENCY    = 3,
  parameter int SHIFT_BITS = 5
) (
  input  logic                  c_clk,
  input  logic                  reset,
  calc1_port_responder_if.slave bus
);

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t            state;
  state_t            state_nxt;
  logic [3:0]        cnt;
  logic [3:0]        cnt_nxt;
  logic              cap_p0;
  logic              cap_p1;
  logic              vld_p2;
  logic              cmd_live;
  logic              drop;

  logic [0:3]        cmd_p0;
  logic [0:DATA_W-1] op1_p0;
  logic [0:DATA_W-1] op2_p1;
  logic [0:1]        alu_resp;
  logic [0:DATA_W-1] alu_data;
  logic [0:1]        resp_p2;
  logic [0:DATA_W-1] data_p2;
  logic [7:0]        drops;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign cmd_live = (bus.req_cmd_in != CMD_NOP);
  assign drop     = (state != IDLE) && cmd_live;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cap_p0    = 1'b0;
    cap_p1    = 1'b0;
    vld_p2    = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_live) begin
          cap_p0    = 1'b1;
          state_nxt = OP2;
        end
      end
      OP2: begin
        cap_p1    = 1'b1;
        cnt_nxt   = CNT_LOAD;
        state_nxt = EXEC;
      end
      EXEC: begin
        if (cnt == 4'd0) begin
          vld_p2    = 1'b1;
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge c_clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      drops   <= 8'd0;
      resp_p2 <= RESP_NONE;
      data_p2 <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (drop) begin
        drops <= sat_inc(drops);
      end
      // stage p2: result registered on entry to RESP, zero otherwise
      resp_p2 <= vld_p2 ? alu_resp : RESP_NONE;
      data_p2 <= vld_p2 ? alu_data : '0;
    end
  end

  // stage p0/p1: command+operand1 then operand2 capture; data path, no reset
  always_ff @(posedge c_clk) begin
    if (cap_p0) begin
      cmd_p0 <= bus.req_cmd_in;
      op1_p0 <= bus.req_data_in;
    end
    if (cap_p1) begin
      op2_p1 <= bus.req_data_in;
    end
  end

  calc1_alu #(
    .SHIFT_BITS (SHIFT_BITS)
  ) u_alu (
    .cmd  (cmd_p0),
    .op1  (op1_p0),
    .op2  (op2_p1),
    .resp (alu_resp),
    .data (alu_data)
  );

  assign bus.out_resp   = resp_p2;
  assign bus.out_data   = data_p2;
  assign bus.busy       = (state != IDLE);
  assign bus.drop_count = drops;

endmodule

// File: tb/tb_calc1_port_responder.sv
// Directed self-checking bench for calc1_port_responder (LATENCY = 3).
module tb_calc1_port_responder;
  import calc1_pkg::*;

  localparam int LAT = 3;

  logic c_clk;
  logic reset;
  int   checks;
  int   errors;
  int   exp_drops;

  calc1_port_responder_if bus ();

  calc1_port_responder #(
    .LATENCY    (LAT),
    .SHIFT_BITS (5)
  ) dut (
    .c_clk (c_clk),
    .reset (reset),
    .bus   (bus)
  );

  initial c_clk = 1'b0;
  always #5 c_clk = ~c_clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge c_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int sat_model(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  // Command in the current cycle (cycle 0), operand2 in cycle 1, response
  // expected in cycle LAT+2. dcmd is presented in busy cycles 1..nd.
  task automatic txn(input string tag, input logic [0:3] cmd,
                     input logic [31:0] op1, input logic [31:0] op2,
                     input logic [1:0] er, input logic [31:0] ed,
                     input logic [0:3] dcmd, input int nd);
    bus.req_cmd_in  = cmd;
    bus.req_data_in = op1;
    step();
    for (int c = 1; c <= LAT + 1; c++) begin
      chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
      chk({tag, "_early_resp"}, 32'(bus.out_resp), 32'd0);
      chk({tag, "_early_data"}, 32'(bus.out_data), 32'd0);
      bus.req_cmd_in  = (c <= nd) ? dcmd : CMD_NOP;
      bus.req_data_in = (c == 1) ? op2 : 32'hDEAD_BEEF;
      if (c <= nd && dcmd != CMD_NOP) exp_drops = sat_model(exp_drops);
      step();
    end
    chk({tag, "_resp"}, 32'(bus.out_resp), 32'(er));
    chk({tag, "_data"}, 32'(bus.out_data), ed);
    chk({tag, "_resp_busy"}, 32'(bus.busy), 32'd1);
    bus.req_cmd_in = (LAT + 2 <= nd) ? dcmd : CMD_NOP;
    if (LAT + 2 <= nd && dcmd != CMD_NOP) exp_drops = sat_model(exp_drops);
    step();
    chk({tag, "_after_resp"}, 32'(bus.out_resp), 32'd0);
    chk({tag, "_after_data"}, 32'(bus.out_data), 32'd0);
    chk({tag, "_after_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_drops"}, 32'(bus.drop_count), 32'(exp_drops));
    bus.req_cmd_in  = CMD_NOP;
    bus.req_data_in = 32'd0;
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    exp_drops       = 0;
    reset           = 1'b1;
    bus.req_cmd_in  = CMD_NOP;
    bus.req_data_in = 32'd0;
    step();
    step();
    chk("rst_resp", 32'(bus.out_resp), 32'd0);
    chk("rst_data", 32'(bus.out_data), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_drops", 32'(bus.drop_count), 32'd0);
    reset = 1'b0;

    // nop in idle must not start a transaction
    bus.req_data_in = 32'hCAFE_F00D;
    step();
    step();
    chk("nop_busy", 32'(bus.busy), 32'd0);
    chk("nop_resp", 32'(bus.out_resp), 32'd0);

    txn("add_basic", CMD_ADD, 32'h0000_0005, 32'h0000_0003, RESP_OK,  32'h0000_0008, CMD_NOP, 0);
    txn("add_ovf",   CMD_ADD, 32'hFFFF_FFFF, 32'h0000_0001, RESP_OVF, 32'h0000_0000, CMD_NOP, 0);
    txn("sub_unf",   CMD_SUB, 32'h0000_0003, 32'h0000_0004, RESP_OVF, 32'h0000_0000, CMD_NOP, 0);
    txn("sub_eq",    CMD_SUB, 32'h0000_0007, 32'h0000_0007, RESP_OK,  32'h0000_0000, CMD_NOP, 0);
    txn("sub_ok",    CMD_SUB, 32'h0001_0000, 32'h0000_0001, RESP_OK,  32'h0000_FFFF, CMD_NOP, 0);
    txn("shl",       CMD_SHL, 32'h0000_0001, 32'hFFFF_FFE4, RESP_OK,  32'h0000_0010, CMD_NOP, 0);
    txn("shr",       CMD_SHR, 32'h8000_0000, 32'h0000_001F, RESP_OK,  32'h0000_0001, CMD_NOP, 0);
    txn("shl_zero",  CMD_SHL, 32'hA5A5_1234, 32'hFFFF_FFE0, RESP_OK,  32'hA5A5_1234, CMD_NOP, 0);
    txn("invalid",   4'h3,    32'h0000_1234, 32'h0000_5678, RESP_INV, 32'h0000_0000, CMD_NOP, 0);
    // accepted in the cycle right after RESP
    txn("add_b2b",   CMD_ADD, 32'h1000_0000, 32'h0000_0ABC, RESP_OK,  32'h1000_0ABC, CMD_NOP, 0);

    // drops in the op2 cycle and two EXEC cycles
    txn("drop_add",  CMD_ADD, 32'h0000_000A, 32'h0000_0014, RESP_OK,  32'h0000_001E, CMD_SUB, 3);
    chk("drop_count3", 32'(bus.drop_count), 32'd3);

    // 300 more drops, five per transaction including the RESP cycle
    for (int i = 0; i < 60; i++) begin
      txn("drop_sat", CMD_ADD, 32'(i), 32'h0000_0100, RESP_OK, 32'(i) + 32'h100, CMD_SUB, 5);
    end
    chk("drop_count255", 32'(bus.drop_count), 32'd255);

    // reset during EXEC aborts silently
    bus.req_cmd_in  = CMD_ADD;
    bus.req_data_in = 32'h0000_0005;
    step();
    bus.req_cmd_in  = CMD_NOP;
    bus.req_data_in = 32'h0000_0006;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_drops = 0;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_resp", 32'(bus.out_resp), 32'd0);
    chk("abort_drops", 32'(bus.drop_count), 32'd0);
    txn("post_rst", CMD_ADD, 32'h0000_0100, 32'h0000_0023, RESP_OK, 32'h0000_0123, CMD_NOP, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
